ad1_uart_streamer: RTL

//  Downstream consumer of the Pmod AD1 interface: takes each completed 12-bit conversion and streams it out

---
 rtl/ad1_uart_pkg.sv | 39 +++
 rtl/uart_tx.sv | 58 +++++
 rtl/ad1_uart_streamer.sv | 109 ++++++++++
 3 files changed

// File: rtl/ad1_uart_pkg.sv
// rtl/ad1_uart_pkg.sv - shared constants, FSM encoding and frame byte helpers for ad1_uart_streamer
// Macro AD1_UART_HEX_EN: defined -> 5-byte ASCII hex frame ("XYZ\r\n"), undefined -> 2 raw bytes.
package ad1_uart_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_NEXT = 2'd3;

`ifdef AD1_UART_HEX_EN
  localparam int FRAME_LEN = 5;
`else
  localparam int FRAME_LEN = 2;
`endif
  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

  // 0-9 -> '0'-'9', 10-15 -> 'A'-'F'
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  function automatic logic [7:0] frame_byte(input logic [11:0] s, input logic [2:0] idx);
`ifdef AD1_UART_HEX_EN
    case (idx)
      3'd0:    return hex_ascii(s[11:8]);
      3'd1:    return hex_ascii(s[7:4]);
      3'd2:    return hex_ascii(s[3:0]);
      3'd3:    return ASCII_CR;
      default: return ASCII_LF;
    endcase
`else
    return (idx == 3'd0) ? {4'h0, s[11:8]} : s[7:0];
`endif
  endfunction

endpackage

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART 8N1 byte transmitter
// Ports: clk, rst (async, active-high), start (accepted only while idle), data[7:0] (latched on start),
//        tx (serial out, idle high), done (1-cycle pulse in the penultimate clock of the stop bit).
// done fires one clock early so a caller that needs a couple of cycles to fetch the next byte can
// restart the line with at most one idle clock between stop and start bits. Requires CLKS_PER_BIT >= 2.
module uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PENULT = CW'(CLKS_PER_BIT - 2);

  logic          active;
  logic [3:0]    bit_idx;   // 0 = start bit, 1..8 = data, 9 = stop bit
  logic [CW-1:0] cnt;
  logic [8:0]    shreg;     // remaining data bits with the stop bit appended on top

  assign done = active && (bit_idx == 4'd9) && (cnt == CNT_PENULT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active  <= 1'b0;
      bit_idx <= 4'd0;
      cnt     <= '0;
      shreg   <= '1;
      tx      <= 1'b1;
    end else if (!active) begin
      if (start) begin
        active  <= 1'b1;
        bit_idx <= 4'd0;
        cnt     <= '0;
        shreg   <= {1'b1, data};
        tx      <= 1'b0;
      end
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      if (bit_idx == 4'd9) begin
        active <= 1'b0;
        tx     <= 1'b1;
      end else begin
        bit_idx <= bit_idx + 4'd1;
        tx      <= shreg[0];
        shreg   <= {1'b1, shreg[8:1]};
      end
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ad1_uart_streamer.sv
// rtl/ad1_uart_streamer.sv - streams each completed Pmod AD1 conversion out over UART 8N1
// Ports: clk, rst (async, active-high), sample[11:0] (ad1 dat), sample_updating (1->0 marks valid),
//        tx (UART out, idle high), busy (frame in flight or sample pending), overrun (sticky drop flag).
// Macro AD1_UART_HEX_EN selects the ASCII hex frame; default build sends two raw bytes.
module ad1_uart_streamer #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] sample,
  input  logic        sample_updating,
  output logic        tx,
  output logic        busy,
  output logic        overrun
);
  import ad1_uart_pkg::*;

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;

  logic        upd_q;
  logic        strobe;
  logic [1:0]  state;
  logic [2:0]  idx;
  logic [11:0] active_s;
  logic [11:0] pending_s;
  logic        pending_full;
  logic        tx_start;
  logic        tx_done;
  logic [7:0]  tx_data;
  logic        frame_end;

  assign strobe    = upd_q & ~sample_updating;
  assign tx_start  = (state == ST_LOAD);
  assign tx_data   = frame_byte(active_s, idx);
  assign frame_end = (state == ST_NEXT) && (idx == LAST_IDX);
  assign busy      = (state != ST_IDLE) | pending_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_q        <= 1'b0;
      state        <= ST_IDLE;
      idx          <= 3'd0;
      active_s     <= 12'd0;
      pending_s    <= 12'd0;
      pending_full <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      upd_q <= sample_updating;

      case (state)
        ST_IDLE: begin
          if (strobe) begin
            active_s <= sample;
            idx      <= 3'd0;
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: state <= ST_SEND;
        ST_SEND: if (tx_done) state <= ST_NEXT;
        ST_NEXT: begin
          if (!frame_end) begin
            idx   <= idx + 3'd1;
            state <= ST_LOAD;
          end else begin
            idx <= 3'd0;
            if (pending_full) begin
              active_s <= pending_s;
              state    <= ST_LOAD;
            end else if (strobe) begin
              // pending is empty, so a coincident sample goes straight to the active slot
              active_s <= sample;
              state    <= ST_LOAD;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Pending slot. At frame end it is drained into active first, so a coincident strobe refills it.
      if (strobe && (state != ST_IDLE)) begin
        if (frame_end) begin
          if (pending_full) pending_s <= sample;
        end else if (!pending_full) begin
          pending_s    <= sample;
          pending_full <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (frame_end && pending_full) begin
        pending_full <= 1'b0;
      end
    end
  end

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk  (clk),
    .rst  (rst),
    .start(tx_start),
    .data (tx_data),
    .tx   (tx),
    .done (tx_done)
  );

endmodule
